// File: rtl/instruction_fetch.sv
// Instruction fetch stage: owns the program counter, issues word reads to a
// synchronous instruction memory, buffers returned words in a 2-entry FIFO
// and hands them to the decoder over a valid/ready handshake. A redirect
// flushes everything in flight or buffered and restarts at the new PC.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_en,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instruction,
  output logic [31:0] out_pc
);

  // Control state.
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic        pending_q, pending_d;
  logic [31:0] pending_pc_q, pending_pc_d;
  logic [1:0]  count_q, count_d;

  // FIFO storage; entry 0 is always the head.
  logic [31:0] fifo_pc_q    [2];
  logic [31:0] fifo_pc_d    [2];
  logic [31:0] fifo_instr_q [2];
  logic [31:0] fifo_instr_d [2];

  logic       pop;
  logic       push;
  logic [2:0] occupancy;
  logic [1:0] count_after_pop;

  // Handshake, credit-based issue decision and head-of-FIFO outputs.
  always_comb begin
    pop       = out_valid & out_ready & ~redirect;
    push      = pending_q & ~redirect;
    // The pop term returns a slot this cycle, allowing one fetch per cycle
    // while the decoder keeps accepting.
    occupancy = {1'b0, count_q} + {2'b00, pending_q} - {2'b00, pop};
    imem_en   = ~reset & ~redirect & (occupancy < 3'd2);
    imem_addr = fetch_pc_q;

    out_valid       = (count_q != 2'd0);
    out_pc          = out_valid ? fifo_pc_q[0]    : 32'h0;
    out_instruction = out_valid ? fifo_instr_q[0] : 32'h0;
  end

  // Next-state: redirect flush, or normal pop/push/issue.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    fetch_pc_d      = fetch_pc_q;
    pending_d       = pending_q;
    pending_pc_d    = pending_pc_q;
    count_d         = count_q;
    fifo_pc_d       = fifo_pc_q;
    fifo_instr_d    = fifo_instr_q;
    count_after_pop = count_q - {1'b0, pop};

    if (redirect) begin
      // The pending response is dropped, not pushed; no issue this cycle.
      count_d    = 2'd0;
      pending_d  = 1'b0;
      fetch_pc_d = redirect_pc & ~32'h3;
    end else begin
      pending_d = imem_en;
      if (imem_en) begin
        fetch_pc_d   = fetch_pc_q + 32'd4;  // wraps silently past 0xFFFF_FFFC
        pending_pc_d = fetch_pc_q;
      end
      // Shift the FIFO on pop before writing the incoming word, so a
      // simultaneous push/pop keeps order.
      if (pop) begin
        fifo_pc_d[0]    = fifo_pc_q[1];
        fifo_instr_d[0] = fifo_instr_q[1];
      end
      if (push) begin
        fifo_pc_d[count_after_pop[0]]    = pending_pc_q;
        fifo_instr_d[count_after_pop[0]] = imem_rdata;
      end
      count_d = count_after_pop + {1'b0, push};
    end
  end

  // Control registers with synchronous reset.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      fetch_pc_q   <= RESET_PC;
      pending_q    <= 1'b0;
      pending_pc_q <= 32'h0;
      count_q      <= 2'd0;
    end else begin
      fetch_pc_q   <= fetch_pc_d;
      pending_q    <= pending_d;
      pending_pc_q <= pending_pc_d;
      count_q      <= count_d;
    end
  end

  // FIFO data registers.
  always_ff @(posedge clock) begin
    // NOTE: the data entries are not reset; count_q qualifies them and the
    // outputs are forced to zero while the FIFO is empty.
    fifo_pc_q    <= fifo_pc_d;
    fifo_instr_q <= fifo_instr_d;
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: sequential fetch, backpressure,
// redirect (with a simultaneous out_ready), mid-stream reset and PC wrap.
// Expected PCs go into a scoreboard queue when a phase is set up and are
// popped on every accepted transfer.
module tb_instruction_fetch;

  logic        clock;
  logic        reset;
  logic        imem_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instruction;
  logic [31:0] out_pc;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q [$];

  localparam logic [31:0] DATA_KEY = 32'hA5A5_0000;

  instruction_fetch #(.RESET_PC(32'h0000_0100)) dut (
    .clock           (clock),
    .reset           (reset),
    .imem_en         (imem_en),
    .imem_addr       (imem_addr),
    .imem_rdata      (imem_rdata),
    .redirect        (redirect),
    .redirect_pc     (redirect_pc),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_instruction (out_instruction),
    .out_pc          (out_pc)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Synchronous memory model: data returns the cycle after the request,
  // junk otherwise so a stray push is visible.
  always @(posedge clock) begin
    if (imem_en) imem_rdata <= imem_addr ^ DATA_KEY;
    else         imem_rdata <= 32'hDEAD_BEEF;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Compare an accepted transfer against the scoreboard head.
  task automatic xfer();
    logic [31:0] e;
    if (out_valid && out_ready && !redirect) begin
      if (exp_q.size() == 0) begin
        check("spurious_xfer_pc", out_pc, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("xfer_pc", out_pc, e);
        check("xfer_instr", out_instruction, e ^ DATA_KEY);
      end
    end
  endtask

  task automatic step_end();
    xfer();
    @(negedge clock);
  endtask

  task automatic run(input int n);
    repeat (n) begin
      #1;
      step_end();
    end
  endtask

  task automatic push_seq(input logic [31:0] start, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(start + 32'(4 * i));
  endtask

  initial begin
    reset       = 1'b1;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    out_ready   = 1'b0;
    imem_rdata  = 32'h0;
    @(negedge clock);
    @(negedge clock);

    // Reset state.
    #1;
    check("rst_valid", {31'b0, out_valid}, 32'd0);
    check("rst_pc", out_pc, 32'h0);
    check("rst_instr", out_instruction, 32'h0);
    check("rst_imem_en", {31'b0, imem_en}, 32'd0);
    @(negedge clock);

    // Sequential fetch: cycle 0 issues RESET_PC, first output in cycle 2.
    reset     = 1'b0;
    out_ready = 1'b1;
    #1;
    check("c0_imem_en", {31'b0, imem_en}, 32'd1);
    check("c0_addr", imem_addr, 32'h100);
    check("c0_valid", {31'b0, out_valid}, 32'd0);
    step_end();
    push_seq(32'h100, 8);
    #1;
    check("c1_valid", {31'b0, out_valid}, 32'd0);
    check("c1_addr", imem_addr, 32'h104);
    step_end();
    #1;
    check("c2_valid", {31'b0, out_valid}, 32'd1);
    step_end();
    run(7);
    check("seq_drained", exp_q.size(), 32'd0);

    // Backpressure for 4 cycles: issue stops, head held stable.
    out_ready = 1'b0;
    push_seq(32'h120, 6);
    for (int i = 0; i < 4; i++) begin
      #1;
      check("bp_imem_en", {31'b0, imem_en}, 32'd0);
      check("bp_pc_hold", out_pc, 32'h120);
      check("bp_valid", {31'b0, out_valid}, 32'd1);
      step_end();
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_en", {31'b0, imem_en}, 32'd1);
    check("bp_release_addr", imem_addr, 32'h128);
    step_end();
    run(5);
    check("bp_drained", exp_q.size(), 32'd0);

    // Redirect with a valid word at the output, out_ready high and a read
    // pending: the word is flushed, not consumed.
    redirect    = 1'b1;
    redirect_pc = 32'h2003;
    #1;
    check("redir_valid_before", {31'b0, out_valid}, 32'd1);
    check("redir_imem_en", {31'b0, imem_en}, 32'd0);
    step_end();
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    push_seq(32'h2000, 4);
    #1;
    check("redir_r1_valid", {31'b0, out_valid}, 32'd0);
    check("redir_r1_pc", out_pc, 32'h0);
    check("redir_r1_en", {31'b0, imem_en}, 32'd1);
    check("redir_r1_addr", imem_addr, 32'h2000);
    step_end();
    #1;
    check("redir_r2_valid", {31'b0, out_valid}, 32'd0);
    step_end();
    #1;
    check("redir_r3_valid", {31'b0, out_valid}, 32'd1);
    check("redir_r3_pc", out_pc, 32'h2000);
    step_end();
    run(3);
    check("redir_drained", exp_q.size(), 32'd0);

    // Fill the FIFO with two words, then reset mid-stream.
    out_ready = 1'b0;
    #1;
    step_end();
    #1;
    check("full_imem_en", {31'b0, imem_en}, 32'd0);
    check("full_head_pc", out_pc, 32'h2010);
    reset = 1'b1;
    #1;
    check("midrst_imem_en", {31'b0, imem_en}, 32'd0);
    step_end();
    reset     = 1'b0;
    out_ready = 1'b1;
    push_seq(32'h100, 3);
    #1;
    check("midrst_valid", {31'b0, out_valid}, 32'd0);
    check("midrst_pc", out_pc, 32'h0);
    check("midrst_instr", out_instruction, 32'h0);
    check("midrst_restart_addr", imem_addr, 32'h100);
    check("midrst_restart_en", {31'b0, imem_en}, 32'd1);
    step_end();
    #1;
    check("midrst_c1_valid", {31'b0, out_valid}, 32'd0);
    step_end();
    run(3);
    check("midrst_drained", exp_q.size(), 32'd0);

    // PC wrap through 0xFFFF_FFFC.
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFF8;
    #1;
    step_end();
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    exp_q.push_back(32'hFFFF_FFF8);
    exp_q.push_back(32'hFFFF_FFFC);
    exp_q.push_back(32'h0000_0000);
    #1;
    check("wrap_addr", imem_addr, 32'hFFFF_FFF8);
    step_end();
    run(4);
    check("wrap_drained", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
